window_gen: RTL and testbench

- Parametrised K×K sliding-window generator for the NPU convolution front end.
- Accepts a raster-order pixel stream, one pixel per accepted cycle.
- Holds K-1 internal line buffers, each IMG_W deep, plus a K×K window register.
- Emits one complete window per valid output position, with optional stride. Handles frame boundaries and back-to-back frames without host intervention.

---
 rtl/window_gen_if.sv | 29 ++
 rtl/window_gen.sv | 157 +++++++++++++++
 tb/tb_window_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// Pixel-stream-in / window-out bundle for window_gen.
// master drives the raster stream and observes windows; slave is the generator.
interface window_gen_if #(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                     in_valid;
  logic [BIT_DEPTH-1:0]     in_pixel;
  logic [K*K*BIT_DEPTH-1:0] win_out;
  logic                     win_valid;
  logic [RW-1:0]            out_row;
  logic [CW-1:0]            out_col;
  logic                     frame_done;

  modport master (
    output in_valid, in_pixel,
    input  win_out, win_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output win_out, win_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_gen.sv
// K x K sliding-window generator: K-1 line buffers feed a shifting window register,
// emitting one window per strided output position of a raster-order frame.
module window_gen #(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int STRIDE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  window_gen_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_START  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_START  = RW'(K - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(STRIDE - 1);

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [PW-1:0]            hphase_q, hphase_d;
  logic [PW-1:0]            vphase_q, vphase_d;
  logic [BIT_DEPTH-1:0]     win_q [K][K];
  logic [BIT_DEPTH-1:0]     win_d [K][K];
  logic [K*K*BIT_DEPTH-1:0] win_out_q, win_out_d;
  logic [RW-1:0]            out_row_q, out_row_d;
  logic [CW-1:0]            out_col_q, out_col_d;
  logic                     win_valid_q, win_valid_d;
  logic                     frame_done_q, frame_done_d;

  logic [BIT_DEPTH-1:0]     line_buf_q [K-1][IMG_W];
  logic [BIT_DEPTH-1:0]     lb_rd [K-1];

  logic col_last, row_last, pos_valid;

  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  // Position gates hide stale line-buffer rows and left columns left over from a wrap.
  assign pos_valid = (col_q >= COL_START) && (row_q >= ROW_START) &&
                     (hphase_q == '0) && (vphase_q == '0);

  // Row r of the new right column comes from the buffer holding the pixel K-1-r rows up.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      lb_rd[r] = line_buf_q[K-2-r][col_q];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hphase_d     = hphase_q;
    vphase_d     = vphase_q;
    win_d        = win_q;
    win_out_d    = win_out_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (bus.in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = lb_rd[r];
      end
      win_d[K-1][K-1] = bus.in_pixel;

      win_valid_d  = pos_valid;
      frame_done_d = col_last && row_last;

      // Phase counters only advance once the window fits, so phase 0 marks a stride hit.
      if (col_last) begin
        col_d    = '0;
        hphase_d = '0;
        if (row_last) begin
          row_d    = '0;
          vphase_d = '0;
        end else begin
          row_d = row_q + RW'(1);
          if (row_q >= ROW_START) begin
            vphase_d = (vphase_q == PHASE_LAST) ? '0 : vphase_q + PW'(1);
          end
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_q >= COL_START) begin
          hphase_d = (hphase_q == PHASE_LAST) ? '0 : hphase_q + PW'(1);
        end
      end

      if (pos_valid) begin
        out_row_d = row_q - ROW_START;
        out_col_d = col_q - COL_START;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            win_out_d[(r*K+c)*BIT_DEPTH +: BIT_DEPTH] = win_d[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hphase_q     <= '0;
      vphase_q     <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_out_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hphase_q     <= hphase_d;
      vphase_q     <= vphase_d;
      win_q        <= win_d;
      win_out_q    <= win_out_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-buffer storage is RAM-like and deliberately left uninitialised.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      line_buf_q[0][col_q] <= bus.in_pixel;
      for (int i = 1; i < K - 1; i++) begin
        line_buf_q[i][col_q] <= line_buf_q[i-1][col_q];
      end
    end
  end

  assign bus.win_out    = win_out_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: 5x5 frames at stride 1 and 2 side by side,
// plus a K=5 instance on a 7x7 frame, checked against a pixel-formula model.
module tb_window_gen;
  logic clk;
  logic rst;

  int total;
  int bad;

  int m_row, m_col, m_base, m_next_base;
  logic [199:0] exp_win1, exp_win2, exp_win3;
  int exp_row1, exp_col1, exp_row2, exp_col2, exp_row3, exp_col3;
  int pulses1, pulses2, pulses3, fds1, fds2, fds3;

  window_gen_if #(.BIT_DEPTH(8), .K(3), .IMG_W(5), .IMG_H(5)) bus1 ();
  window_gen_if #(.BIT_DEPTH(8), .K(3), .IMG_W(5), .IMG_H(5)) bus2 ();
  window_gen_if #(.BIT_DEPTH(8), .K(5), .IMG_W(7), .IMG_H(7)) bus3 ();

  window_gen #(.BIT_DEPTH(8), .K(3), .IMG_W(5), .IMG_H(5), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  window_gen #(.BIT_DEPTH(8), .K(3), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );
  window_gen #(.BIT_DEPTH(8), .K(5), .IMG_W(7), .IMG_H(7), .STRIDE(1)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [199:0] exp_window(input int base, input int orow, input int ocol,
                                              input int k, input int w);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        v[(r*k+c)*8 +: 8] = 8'(base + (orow + r) * w + ocol + c);
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [199:0] act, input logic [199:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic clearModel();
    m_row = 0; m_col = 0;
    exp_win1 = '0; exp_win2 = '0; exp_win3 = '0;
    exp_row1 = 0; exp_col1 = 0; exp_row2 = 0; exp_col2 = 0; exp_row3 = 0; exp_col3 = 0;
  endtask

  task automatic clearCounts();
    pulses1 = 0; pulses2 = 0; pulses3 = 0; fds1 = 0; fds2 = 0; fds3 = 0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus2.in_valid = 1'b0; bus3.in_valid = 1'b0;
    @(posedge clk);
    #1;
    clearModel();
    checkOutput("rst_win_valid1", bus1.win_valid, 0);
    checkOutput("rst_frame_done1", bus1.frame_done, 0);
    checkOutput("rst_win_out1", bus1.win_out, 0);
    checkOutput("rst_out_row1", bus1.out_row, 0);
    checkOutput("rst_out_col1", bus1.out_col, 0);
    checkOutput("rst_win_valid2", bus2.win_valid, 0);
    checkOutput("rst_win_out3", bus3.win_out, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle on the two 5x5 instances; v selects a real pixel or an idle cycle.
  task automatic applyStimulus(input bit v);
    int  pix;
    bit  ev1, ev2, efd;
    pix = m_base + m_row * 5 + m_col;
    @(negedge clk);
    bus1.in_valid = v; bus1.in_pixel = 8'(pix);
    bus2.in_valid = v; bus2.in_pixel = 8'(pix);
    @(posedge clk);
    #1;
    ev1 = 1'b0; ev2 = 1'b0; efd = 1'b0;
    if (v) begin
      ev1 = (m_row >= 2) && (m_col >= 2);
      ev2 = ev1 && ((m_row - 2) % 2 == 0) && ((m_col - 2) % 2 == 0);
      efd = (m_row == 4) && (m_col == 4);
      if (ev1) begin
        exp_win1 = exp_window(m_base, m_row - 2, m_col - 2, 3, 5);
        exp_row1 = m_row - 2; exp_col1 = m_col - 2;
      end
      if (ev2) begin
        exp_win2 = exp_window(m_base, m_row - 2, m_col - 2, 3, 5);
        exp_row2 = m_row - 2; exp_col2 = m_col - 2;
      end
      if (m_col == 4) begin
        m_col = 0;
        if (m_row == 4) begin
          m_row  = 0;
          m_base = m_next_base;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    if (bus1.win_valid === 1'b1) pulses1++;
    if (bus2.win_valid === 1'b1) pulses2++;
    if (bus1.frame_done === 1'b1) fds1++;
    if (bus2.frame_done === 1'b1) fds2++;
    checkOutput("win_valid1", bus1.win_valid, ev1);
    checkOutput("frame_done1", bus1.frame_done, efd);
    checkOutput("win_out1", bus1.win_out, exp_win1);
    checkOutput("out_row1", bus1.out_row, exp_row1);
    checkOutput("out_col1", bus1.out_col, exp_col1);
    checkOutput("win_valid2", bus2.win_valid, ev2);
    checkOutput("frame_done2", bus2.frame_done, efd);
    checkOutput("win_out2", bus2.win_out, exp_win2);
    checkOutput("out_row2", bus2.out_row, exp_row2);
    checkOutput("out_col2", bus2.out_col, exp_col2);
  endtask

  // One accepted pixel on the K=5, 7x7 instance; pixel = row*7+col+1.
  task automatic applyStimulusK5();
    bit ev, efd;
    @(negedge clk);
    bus3.in_valid = 1'b1;
    bus3.in_pixel = 8'(m_row * 7 + m_col + 1);
    @(posedge clk);
    #1;
    ev  = (m_row >= 4) && (m_col >= 4);
    efd = (m_row == 6) && (m_col == 6);
    if (ev) begin
      exp_win3 = exp_window(1, m_row - 4, m_col - 4, 5, 7);
      exp_row3 = m_row - 4; exp_col3 = m_col - 4;
    end
    if (m_col == 6) begin
      m_col = 0;
      m_row = (m_row == 6) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    if (bus3.win_valid === 1'b1) pulses3++;
    if (bus3.frame_done === 1'b1) fds3++;
    checkOutput("win_valid3", bus3.win_valid, ev);
    checkOutput("frame_done3", bus3.frame_done, efd);
    checkOutput("win_out3", bus3.win_out, exp_win3);
    checkOutput("out_row3", bus3.out_row, exp_row3);
    checkOutput("out_col3", bus3.out_col, exp_col3);
  endtask

  initial begin
    logic [15:0] gap_pat;
    int          acc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_pixel = '0;
    bus2.in_valid = 1'b0; bus2.in_pixel = '0;
    bus3.in_valid = 1'b0; bus3.in_pixel = '0;
    m_base = 1; m_next_base = 1;
    clearModel();
    clearCounts();

    $display("[TB] reset state");
    applyReset();

    $display("[TB] continuous 5x5 frame, stride 1 and 2");
    clearCounts();
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1);
      if (i == 12) checkOutput("first_window", bus1.win_out[71:0], 72'h0D_0C_0B_08_07_06_03_02_01);
      if (i == 14) checkOutput("stride2_0_2", bus2.win_out[71:0], 72'h0F_0E_0D_0A_09_08_05_04_03);
    end
    checkOutput("last_window", bus1.win_out[71:0], 72'h19_18_17_14_13_12_0F_0E_0D);
    checkOutput("pulses_s1", pulses1, 9);
    checkOutput("pulses_s2", pulses2, 4);
    checkOutput("frame_done_s1", fds1, 1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    $display("[TB] 5x5 frame with input gaps");
    clearCounts();
    gap_pat = 16'b1011_0010_1101_0110;
    acc = 0;
    for (int i = 0; i < 200 && acc < 25; i++) begin
      applyStimulus(gap_pat[i % 16]);
      if (gap_pat[i % 16]) acc++;
    end
    checkOutput("gap_accepted", acc, 25);
    checkOutput("pulses_gap1", pulses1, 9);
    checkOutput("pulses_gap2", pulses2, 4);
    checkOutput("frame_done_gap", fds1, 1);

    $display("[TB] reset mid-frame then clean frame");
    clearCounts();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1);
    applyReset();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1);
    checkOutput("pulses_abort1", pulses1, 9);
    checkOutput("frame_done_abort", fds1, 1);
    checkOutput("last_window_abort", bus1.win_out[71:0], 72'h19_18_17_14_13_12_0F_0E_0D);

    $display("[TB] back-to-back frames");
    clearCounts();
    m_base = 1; m_next_base = 100;
    for (int i = 0; i < 38; i++) applyStimulus(1'b1);
    checkOutput("frame2_first", bus1.win_out[71:0], 72'h70_6F_6E_6B_6A_69_66_65_64);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1);
    checkOutput("pulses_b2b", pulses1, 18);
    checkOutput("pulses_b2b_s2", pulses2, 8);
    checkOutput("frame_done_b2b", fds1, 2);
    applyStimulus(1'b0);

    $display("[TB] K=5 on 7x7 frame");
    applyReset();
    clearCounts();
    for (int i = 0; i < 49; i++) applyStimulusK5();
    checkOutput("pulses_k5", pulses3, 9);
    checkOutput("frame_done_k5", fds3, 1);
    checkOutput("k5_tap44", bus3.win_out[24*8 +: 8], 8'd49);
    checkOutput("k5_last_row", bus3.out_row, 2);
    checkOutput("k5_last_col", bus3.out_col, 2);
    @(negedge clk);
    bus3.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
